// File: rtl/mos6502_int_seq.sv
// Interrupt/reset entry sequencer for the mos6502 core: NMI edge capture, request
// priority and the 7-cycle RESET/NMI/IRQ/BRK entry bus sequence with vector fetch.
module mos6502_int_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        rdy,
   input  logic        IRQ,
   input  logic        NMI,
   input  logic        sync,
   input  logic        brk_req,
   input  logic        i_flag,
   input  logic [15:0] pc_in,
   input  logic [7:0]  psr_in,
   input  logic [7:0]  sp_in,
   input  logic [7:0]  d_in,
   output logic        busy,
   output logic [15:0] add_bus,
   output logic [7:0]  d_out,
   output logic        write_en,
   output logic        sp_dec,
   output logic        pc_load,
   output logic [15:0] pc_vec,
   output logic        set_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
   } state_t;

   typedef enum logic [1:0] {K_RST, K_NMI, K_IRQ, K_BRK} kind_t;

   state_t      state, state_next;
   kind_t       kind, kind_next;
   logic        nmi_prev, nmi_pend, nmi_clr, nmi_fall, irq_ok, stacking;
   logic [7:0]  vlo, vlo_next;
   logic [15:0] vec_addr, stack_addr;

   assign nmi_fall   = nmi_prev & ~NMI;
   assign irq_ok     = ~IRQ & ~i_flag;
   assign stack_addr = {8'h01, sp_in};
   assign stacking   = (state == S_T3) || (state == S_T4) || (state == S_T5);

   always_comb begin
      case (kind)
         K_NMI:   vec_addr = 16'hFFFA;
         K_RST:   vec_addr = 16'hFFFC;
         default: vec_addr = 16'hFFFE;
      endcase
   end

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      kind_next  = kind;
      vlo_next   = vlo;
      nmi_clr    = 1'b0;
      if (rdy) begin
         case (state)
            S_IDLE: begin
               if (sync) begin
                  if (nmi_pend) begin
                     state_next = S_T1;
                     kind_next  = K_NMI;
                  end else if (brk_req) begin
                     state_next = S_T1;
                     kind_next  = K_BRK;
                  end else if (irq_ok) begin
                     state_next = S_T1;
                     kind_next  = K_IRQ;
                  end
               end
            end
            S_T1: state_next = S_T2;
            S_T2: state_next = S_T3;
            S_T3: state_next = S_T4;
            S_T4: state_next = S_T5;
            S_T5: begin
               state_next = S_T6;
               // A pending NMI takes over a maskable entry before its vector is fetched.
               if (nmi_pend && (kind == K_IRQ || kind == K_BRK)) begin
                  kind_next = K_NMI;
                  nmi_clr   = 1'b1;
               end
            end
            S_T6: begin
               state_next = S_T7;
               vlo_next   = d_in;
               nmi_clr    = (kind == K_NMI);
            end
            S_T7:    state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_T1;
         kind     <= K_RST;
         nmi_prev <= 1'b1;
         nmi_pend <= 1'b0;
         vlo      <= 8'h00;
      end else begin
         state    <= state_next;
         kind     <= kind_next;
         vlo      <= vlo_next;
         nmi_prev <= NMI;
         nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_fall;
      end
   end

   always_comb begin
      busy     = 1'b1;
      add_bus  = 16'h0000;
      d_out    = 8'h00;
      write_en = 1'b1;
      sp_dec   = 1'b0;
      pc_load  = 1'b0;
      pc_vec   = 16'h0000;
      set_i    = 1'b0;
      if (!reset) begin
         busy = (state != S_IDLE);
         case (state)
            S_T1, S_T2: add_bus = pc_in;
            S_T3: begin
               add_bus = stack_addr;
               d_out   = pc_in[15:8];
            end
            S_T4: begin
               add_bus = stack_addr;
               d_out   = pc_in[7:0];
            end
            S_T5: begin
               add_bus = stack_addr;
               d_out   = {psr_in[7:6], 1'b1, (kind == K_BRK), psr_in[3:0]};
            end
            S_T6: add_bus = vec_addr;
            S_T7: begin
               add_bus = vec_addr + 16'd1;
               pc_vec  = {d_in, vlo};
               pc_load = rdy;
               set_i   = rdy;
            end
            default: ;
         endcase
         // Reset entry performs the push cycles as reads but still walks SP down.
         if (stacking) begin
            write_en = (kind == K_RST);
            sp_dec   = rdy;
         end
      end
   end

endmodule

// File: doc/mos6502_int_seq.md
# mos6502_int_seq

Interrupt/reset entry sequencer for the mos6502 core. Sits beside the main microcode sequencer and, when granted the bus at an instruction boundary, drives the 7-cycle entry sequence for RESET, NMI, IRQ and BRK: two dummy reads, three stack pushes (PCH, PCL, P) and a two-byte vector fetch. It then loads the PC and sets I. It owns NMI edge detection, IRQ masking and request priority.

## Interface
- No parameters. Vectors are fixed: NMI 16'hFFFA, RESET 16'hFFFC, IRQ/BRK 16'hFFFE.
- clk  in  1  CPU clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- rdy  in  1  1 = advance; 0 = freeze state and all outputs.
- IRQ  in  1  active-low level interrupt request.
- NMI  in  1  active-low non-maskable interrupt; falling edge is latched.
- sync  in  1  main sequencer is at an instruction boundary (opcode-fetch cycle).
- brk_req  in  1  BRK decoded; valid only with sync.
- i_flag  in  1  current I flag.
- pc_in  in  16  return address to push.
- psr_in  in  8  current P for push.
- sp_in  in  8  current stack pointer.
- d_in  in  8  read data bus.
- busy  out  1  sequencer owns the bus; main sequencer holds.
- add_bus  out  16  address while busy.
- d_out  out  8  write data while busy.
- write_en  out  1  active-low write strobe.
- sp_dec  out  1  decrement SP this cycle.
- pc_load  out  1  load pc_vec into PC this cycle.
- pc_vec  out  16  vector target.
- set_i  out  1  set I flag this cycle.

## Operation
- States: IDLE, T1, T2, T3 (PCH), T4 (PCL), T5 (P), T6 (VLO), T7 (VHI).
- Source register kind ∈ {RST, NMI, IRQ, BRK}; chosen on the IDLE→T1 edge.
- Priority on the IDLE→T1 edge: RST > NMI pending > BRK > IRQ.
  - IRQ is taken only if IRQ==0 and i_flag==0.
  - Leave IDLE only when sync==1 and a request exists. Reset forces RST regardless of sync.
- NMI: nmi_prev register; falling edge (prev 1, now 0) sets nmi_pend. nmi_pend clears on the T6→T7 edge when kind==NMI, or after hijack.
  - An edge arriving while busy stays pending and is serviced at the next boundary.
- T1, T2: read at pc_in, write_en=1.
- T3: add_bus={8'h01,sp_in}, d_out=pc_in[15:8].
- T4: add_bus={8'h01,sp_in}, d_out=pc_in[7:0].
- T5: add_bus={8'h01,sp_in}, d_out = psr_in with bit5=1, bit4=(kind==BRK).
- T3–T5: write_en=0 except kind==RST, where write_en stays 1 (reads only). sp_dec=1 for all kinds.
- Stack address is the low-byte wrap, so sp_in=8'h00 addresses 16'h0100.
- Hijack: if nmi_pend is set on the T5→T6 edge and kind∈{IRQ,BRK}, kind becomes NMI and nmi_pend clears. The pushed B bit is unchanged.
- T6: add_bus=vector low address; d_in latched into vlo.
- T7: add_bus=vector+1; pc_vec={d_in,vlo}; pc_load=1, set_i=1; next state IDLE.
- busy=1 in T1–T7, 0 in IDLE.

## Timing
- During reset: state=T1 held, kind=RST, nmi_pend=0, nmi_prev=1, vlo=0.
- Reset-held output values: busy=1, add_bus=16'h0000, d_out=0, write_en=1, sp_dec=0, pc_load=0, set_i=0, pc_vec=0.
- First cycle after reset deasserts executes T1; pc_load occurs 7 cycles after deassert.
- Entry latency: request seen with sync at edge k → T1 during cycle k+1 → pc_load in cycle k+7.
- busy drops the cycle after T7. The sequencer can accept the next request only after a fresh sync.
- rdy=0: no state change, no sp_dec/pc_load/set_i pulses (gated by rdy), and outputs hold. NMI edge detection continues during rdy=0.
- Reset mid-sequence: abort immediately and restart RST from T1. Pushes already issued are not undone.
- IRQ deasserted after the IRQ→T1 decision: the sequence completes unchanged.
- IRQ and NMI simultaneous at a boundary: NMI is taken, IRQ stays pending if still low.
- Single-cycle outputs (pc_load, set_i, sp_dec) are strobes of exactly one cycle per state.

## Test plan
- Reset: reset=1 for 3 cycles, release; d_in=8'h34 at FFFC, 8'h12 at FFFD → write_en stays 1 all cycles, 3 sp_dec pulses, pc_load with pc_vec=16'h1234 on the 7th cycle.
- IRQ: i_flag=0, IRQ=0, sync, pc_in=16'hC123, psr_in=8'h81, sp_in=8'hFD → writes 8'hC1@01FD, 8'h23@01FC, 8'hA1@01FB, vector FFFE.
- IRQ masked: i_flag=1, IRQ=0 for 20 syncs → busy never asserts.
- BRK with NMI hijack: brk_req at sync, NMI falls during T3 → P pushed with bit4=1, vector fetched from FFFA/FFFB, nmi_pend cleared.
- NMI while busy: NMI edge during an IRQ T6 → IRQ completes via FFFE; at the next sync an NMI sequence starts.
- rdy stall: rdy=0 for 4 cycles in T4 → add_bus/d_out held, one sp_dec total for T4, pc_load delayed by 4 cycles; separately, reset asserted in T5 → restarts at T1 with kind RST.
